// File: rtl/ram_sched_pkg.sv
// Shared types and constants for the four-port RAM scheduler.
package ram_sched_pkg;
    localparam int NUM_PORTS  = 4;
    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_CAPTURE,
        DONE
    } state_e;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] idx);
        return NUM_PORTS'(1) << idx;
    endfunction
endpackage

// File: rtl/ram_scheduler_if.sv
// Requester bus plus single-port RAM strobes for the scheduler.
interface ram_scheduler_if #(
    parameter int ADDR_W = ram_sched_pkg::ADDR_W_DEF,
    parameter int DATA_W = ram_sched_pkg::DATA_W_DEF
);
    localparam int NP = ram_sched_pkg::NUM_PORTS;

    logic [NP-1:0]             req;
    logic [NP-1:0]             we;
    logic [NP-1:0][ADDR_W-1:0] addr;
    logic [NP-1:0][DATA_W-1:0] wdata;
    logic [NP-1:0]             done;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;
    logic                      ram_en;
    logic                      ram_we;
    logic [ADDR_W-1:0]         ram_addr;
    logic [DATA_W-1:0]         ram_wdata;
    logic [DATA_W-1:0]         ram_rdata;

    modport slave (
        input  req, we, addr, wdata, ram_rdata,
        output done, rdata, busy, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output req, we, addr, wdata, ram_rdata,
        input  done, rdata, busy, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram_scheduler_rr_picker.sv
// Combinational round-robin picker: first asserted request above 'last', wrapping.
module rr_picker
    import ram_sched_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [1:0]           last,
    output logic                 valid,
    output logic [1:0]           idx
);
    // Scan from the farthest candidate back toward last+1 so the nearest one wins.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req[last + 2'(k + 1)]) idx = last + 2'(k + 1);
        end
    end
endmodule

// File: rtl/ram_scheduler.sv
// Four-port round-robin scheduler in front of a single-port, one-cycle-read RAM.
module ram_scheduler
    import ram_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          reset,
    ram_scheduler_if.slave bus
);
    state_e            state, state_nxt;
    logic [1:0]        last;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              pick_vld;
    logic [1:0]        pick_idx;

    rr_picker u_pick (
        .req   (bus.req),
        .last  (last),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (pick_vld) state_nxt = bus.we[pick_idx] ? WR : RD_ISSUE;
            WR:         state_nxt = DONE;
            RD_ISSUE:   state_nxt = RD_CAPTURE;
            RD_CAPTURE: state_nxt = DONE;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // 'last' doubles as the in-flight winner index until the next grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= 2'd3;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_vld) begin
                last      <= pick_idx;
                lat_addr  <= bus.addr[pick_idx];
                lat_wdata <= bus.wdata[pick_idx];
            end
            if (state == RD_CAPTURE) rdata_q <= bus.ram_rdata;
        end
    end

    assign bus.ram_en    = (state == WR) || (state == RD_ISSUE);
    assign bus.ram_we    = (state == WR);
    assign bus.ram_addr  = lat_addr;
    assign bus.ram_wdata = lat_wdata;
    assign bus.done      = (state == DONE) ? port_onehot(last) : '0;
    assign bus.busy      = (state != IDLE);
    assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_ram_scheduler.sv
// Scoreboard bench for ram_scheduler: directed stimulus, decoupled done monitor.
module tb_ram_scheduler;
    import ram_sched_pkg::*;

    localparam int AW = 9;
    localparam int DW = 8;

    typedef struct {
        int          port;
        bit          rd;
        logic [DW-1:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit [3:0] hold = '0;
    exp_t sbq[$];
    exp_t e;
    int   c0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_scheduler #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial for (int a = 0; a < (1 << AW); a++) mem[a] = 8'(a) ^ 8'h5A;

    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= mem[bus.ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.we[p]    = w;
        bus.addr[p]  = a;
        bus.wdata[p] = d;
        bus.req[p]   = 1'b1;
    endtask

    task automatic push(input int p, input bit rd, input logic [DW-1:0] d, input int c);
        exp_t x;
        x.port = p; x.rd = rd; x.data = d; x.cyc = c;
        sbq.push_back(x);
    endtask

    // Requester side: drop req in the done cycle unless the port keeps re-requesting.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (bus.done[i] && !hold[i]) bus.req[i] = 1'b0;
    end

    always @(negedge clk) begin
        if (bus.done !== 4'b0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'(bus.done), 32'h0);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("done_p%0d", e.port), 32'(bus.done), 32'(4'b1 << e.port));
                if (e.rd) chk($sformatf("rdata_p%0d", e.port), 32'(bus.rdata), 32'(e.data));
                chk($sformatf("done_cycle_p%0d", e.port), cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_done",   32'(bus.done),      0);
        chk("rst_busy",   32'(bus.busy),      0);
        chk("rst_ram_en", 32'(bus.ram_en),    0);
        chk("rst_ram_we", 32'(bus.ram_we),    0);
        chk("rst_addr",   32'(bus.ram_addr),  0);
        chk("rst_wdata",  32'(bus.ram_wdata), 0);
        chk("rst_rdata",  32'(bus.rdata),     0);
        reset = 1'b1;
        @(negedge clk);

        // Port 2 write; inputs changed right after the grant must not leak in.
        c0 = cyc;
        issue(2, 1'b1, 9'h1A5, 8'h3C);
        push(2, 1'b0, 8'h00, c0 + 2);
        @(negedge clk);
        bus.addr[2] = 9'h000; bus.wdata[2] = 8'hEE;
        chk("wr_ram_en",   32'(bus.ram_en),    1);
        chk("wr_ram_we",   32'(bus.ram_we),    1);
        chk("wr_ram_addr", 32'(bus.ram_addr),  32'h1A5);
        chk("wr_ram_data", 32'(bus.ram_wdata), 32'h3C);
        repeat (2) @(negedge clk);
        chk("wr_idle_busy", 32'(bus.busy),   0);
        chk("wr_idle_en",   32'(bus.ram_en), 0);

        // Port 0 read of the same address.
        c0 = cyc;
        issue(0, 1'b0, 9'h1A5, 8'h00);
        push(0, 1'b1, 8'h3C, c0 + 3);
        @(negedge clk);
        chk("rd_ram_en",   32'(bus.ram_en),   1);
        chk("rd_ram_we",   32'(bus.ram_we),   0);
        chk("rd_ram_addr", 32'(bus.ram_addr), 32'h1A5);
        bus.addr[0] = 9'h000; bus.we[0] = 1'b1;
        @(negedge clk);
        chk("rd_cap_en",   32'(bus.ram_en), 0);
        chk("rd_cap_busy", 32'(bus.busy),   1);
        repeat (2) @(negedge clk);

        // Fresh reset, then all four ports read at once.
        reset = 1'b0; @(negedge clk); reset = 1'b1; @(negedge clk);
        c0 = cyc;
        for (int p = 0; p < 4; p++) begin
            issue(p, 1'b0, AW'(9'h010 + p), 8'h00);
            push(p, 1'b1, (8'h10 + 8'(p)) ^ 8'h5A, c0 + 3 + 4 * p);
        end
        repeat (16) @(negedge clk);
        chk("all4_idle", 32'(bus.busy), 0);

        // Ports 1 and 3 re-request; port 0 arrives while 3 is served.
        c0 = cyc;
        hold[1] = 1'b1; hold[3] = 1'b1;
        issue(1, 1'b1, 9'h020, 8'h11);
        issue(3, 1'b1, 9'h030, 8'h33);
        push(1, 1'b0, 8'h00, c0 + 2);
        push(3, 1'b0, 8'h00, c0 + 5);
        push(1, 1'b0, 8'h00, c0 + 8);
        push(3, 1'b0, 8'h00, c0 + 11);
        push(0, 1'b0, 8'h00, c0 + 14);
        push(1, 1'b0, 8'h00, c0 + 17);
        repeat (10) @(negedge clk);
        chk("rr_p3_addr", 32'(bus.ram_addr), 32'h030);
        issue(0, 1'b1, 9'h040, 8'h44);
        repeat (6) @(negedge clk);
        chk("rr_p1_addr", 32'(bus.ram_addr), 32'h020);
        hold[1] = 1'b0; hold[3] = 1'b0; bus.req[3] = 1'b0;
        repeat (2) @(negedge clk);
        chk("rr_idle", 32'(bus.busy), 0);

        // Reset lands in RD_CAPTURE of a port 2 read: transaction must vanish.
        c0 = cyc;
        issue(2, 1'b0, 9'h1FF, 8'h00);
        @(negedge clk);
        chk("abort_issue_en", 32'(bus.ram_en),   1);
        chk("abort_addr",     32'(bus.ram_addr), 32'h1FF);
        @(negedge clk);
        chk("abort_cap_en", 32'(bus.ram_en), 0);
        reset = 1'b0; bus.req[2] = 1'b0;
        @(negedge clk);
        chk("abort_done",  32'(bus.done),      0);
        chk("abort_busy",  32'(bus.busy),      0);
        chk("abort_en",    32'(bus.ram_en),    0);
        chk("abort_we",    32'(bus.ram_we),    0);
        chk("abort_raddr", 32'(bus.ram_addr),  0);
        chk("abort_wdata", 32'(bus.ram_wdata), 0);
        chk("abort_rdata", 32'(bus.rdata),     0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_after_en", 32'(bus.ram_en), 0);
        chk("abort_after_busy", 32'(bus.busy), 0);

        c0 = cyc;
        issue(2, 1'b0, 9'h1FF, 8'h00);
        push(2, 1'b1, 8'hA5, c0 + 3);
        repeat (4) @(negedge clk);

        for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
